uart_tx_fifo: RTL

//   Byte FIFO that sits directly upstream of the uart block's transmitter. User logic pushes

---
 rtl/uart_tx_fifo.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   Byte FIFO feeding a uart transmitter. User logic pushes bytes with a
//   valid/ready handshake. The block hands them to the uart one at a time. Each
//   byte gets exactly one single-cycle trigger pulse, and the block then waits
//   for the uart to report busy and then idle again before it sends the next
//   byte.
//
// Ports
//   clk_i          in   1           system clock, rising edge
//   rst_ni         in   1           synchronous reset, active low
//   wr_data_i      in   8           byte to enqueue
//   wr_valid_i     in   1           enqueue request
//   wr_ready_o     out  1           FIFO can accept (push = valid & ready)
//   flush_i        in   1           discard all queued bytes
//   level_o        out  ADDR_W+1    queued bytes (byte in flight excluded)
//   tx_data_o      out  8           byte presented to the uart
//   tx_trigger_o   out  1           one-cycle start pulse to the uart
//   tx_complete_i  in   1           uart idle indication (1 = idle)
//   idle_o         out  1           FIFO empty and sequencer idle
//   timeout_o      out  1           sticky: a trigger was never acknowledged
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DEPTH        = 16,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [7:0]               wr_data_i,
    input  logic                     wr_valid_i,
    output logic                     wr_ready_o,
    input  logic                     flush_i,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [7:0]               tx_data_o,
    output logic                     tx_trigger_o,
    input  logic                     tx_complete_i,
    output logic                     idle_o,
    output logic                     timeout_o
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;
    localparam int TMO_W  = $clog2(BUSY_TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;

    localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);

    // Storage and FIFO bookkeeping
    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q,  count_d;

    // Transmit sequencer
    logic [1:0]        state_q,   state_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              trig_q,    trig_d;
    logic              tmo_flag_q, tmo_flag_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;

    logic push_s;
    logic pop_s;

    assign wr_ready_o   = (count_q != FULL_LVL);
    assign level_o      = count_q;
    assign tx_data_o    = tx_data_q;
    assign tx_trigger_o = trig_q;
    assign timeout_o    = tmo_flag_q;
    assign idle_o       = (count_q == {CNT_W{1'b0}}) && (state_q == ST_IDLE);

    assign push_s = wr_valid_i & wr_ready_o;
    // A byte leaves the FIFO only when the uart is idle and no flush is pending;
    // the flush wins so a flushed byte can never be triggered.
    assign pop_s  = (state_q == ST_IDLE) && (count_q != {CNT_W{1'b0}})
                    && tx_complete_i && !flush_i;

    // FIFO pointer and count next-state; flush overrides push and pop
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = {ADDR_W{1'b0}};
            rd_ptr_d = {ADDR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
                default: count_d = count_q;
            endcase
        end
    end

    // Transmit sequencer next-state
    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        trig_d     = 1'b0;
        tmo_flag_d = tmo_flag_q;
        tmo_cnt_d  = tmo_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pop_s) begin
                    tx_data_d = mem_q[rd_ptr_q];
                    trig_d    = 1'b1;
                    tmo_cnt_d = {TMO_W{1'b0}};
                    state_d   = ST_WAIT_BUSY;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_WAIT_BUSY: begin
                // The uart acknowledges a trigger by dropping tx_complete; if it
                // never does, the byte is written off and the flag latches.
                if (!tx_complete_i) begin
                    state_d = ST_WAIT_DONE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    tmo_flag_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + {{(TMO_W-1){1'b0}}, 1'b1};
                end
            end
            ST_WAIT_DONE: begin
                if (tx_complete_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Byte storage; contents are intentionally not reset
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q   <= {ADDR_W{1'b0}};
            rd_ptr_q   <= {ADDR_W{1'b0}};
            count_q    <= {CNT_W{1'b0}};
            state_q    <= ST_IDLE;
            tx_data_q  <= 8'h00;
            trig_q     <= 1'b0;
            tmo_flag_q <= 1'b0;
            tmo_cnt_q  <= {TMO_W{1'b0}};
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            trig_q     <= trig_d;
            tmo_flag_q <= tmo_flag_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

endmodule
